// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - state encodings and latched transfer-mode record for the SPI master
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LEAD  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
    logic hold_cs;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator, reloaded with a new divider on accept
module spi_clk_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_i) begin
      div_d = div_i;
      cnt_d = div_i;
    end else if (cnt_q == '0) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - SPI master with per-transfer width, CPOL/CPHA, bit order, divider and CS hold
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter  int MAX_WIDTH = 16,
  parameter  int DIV_WIDTH = 8,
  parameter  int NUM_CS    = 2,
  localparam int WW        = $clog2(MAX_WIDTH + 1),
  localparam int CW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 raw_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic [WW-1:0]        width,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [CW-1:0]        cs_index,
  input  logic                 hold_cs,
  input  logic [MAX_WIDTH-1:0] data_tx,
  output logic [MAX_WIDTH-1:0] data_rx,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic [NUM_CS-1:0]    cs_n
);

  logic [2:0]           state_q, state_d;
  spi_mode_t            mode_q, mode_d;
  logic [WW-1:0]        w_q, w_d, bits_q, bits_d;
  logic [MAX_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, data_rx_q, data_rx_d;
  logic                 sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic [NUM_CS-1:0]    cs_n_q, cs_n_d;

  logic                 tick, accept;
  logic [WW-1:0]        w_in;
  logic [MAX_WIDTH-1:0] tx_masked, tx_first;
  logic [NUM_CS-1:0]    cs_sel;
  logic                 enter_lead, enter_trail, do_sample, do_drive;

  assign accept = start && (state_q == ST_IDLE);

  spi_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_clk_div (
    .clk_i   (raw_clk),
    .rst_n_i (reset_n),
    .load_i  (accept),
    .div_i   (clk_div),
    .tick_o  (tick)
  );

  // The tx register always presents the next outgoing bit at its MSB, whatever the bit order.
  always_comb begin
    w_in = width;
    if (width == '0 || int'(width) > MAX_WIDTH) w_in = WW'(MAX_WIDTH);
    tx_masked = data_tx & ({MAX_WIDTH{1'b1}} >> (MAX_WIDTH - int'(w_in)));
    tx_first  = tx_masked << (MAX_WIDTH - int'(w_in));
    if (lsb_first) begin
      for (int i = 0; i < MAX_WIDTH; i++) tx_first[MAX_WIDTH-1-i] = tx_masked[i];
    end
    cs_sel = '1;
    if (int'(cs_index) < NUM_CS) cs_sel[cs_index] = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    w_d         = w_q;
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    data_rx_d   = data_rx_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    done_d      = 1'b0;
    enter_lead  = 1'b0;
    enter_trail = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        mode_d.cpol      = cpol;
        mode_d.cpha      = cpha;
        mode_d.lsb_first = lsb_first;
        mode_d.hold_cs   = hold_cs;
        w_d     = w_in;
        bits_d  = w_in;
        rx_d    = '0;
        sclk_d  = cpol;
        cs_n_d  = cs_sel;
        state_d = ST_SETUP;
        if (cpha) begin
          mosi_d = 1'b0;
          tx_d   = tx_first;
        end else begin
          mosi_d = tx_first[MAX_WIDTH-1];
          tx_d   = tx_first << 1;
        end
      end
      ST_SETUP: if (tick) begin
        state_d    = ST_LEAD;
        enter_lead = 1'b1;
      end
      ST_LEAD: if (tick) begin
        state_d     = ST_TRAIL;
        enter_trail = 1'b1;
      end
      ST_TRAIL: if (tick) begin
        if (bits_q == '0) begin
          state_d = ST_HOLD;
          sclk_d  = mode_q.cpol;
        end else begin
          state_d    = ST_LEAD;
          enter_lead = 1'b1;
        end
      end
      ST_HOLD: if (tick) begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        mosi_d    = 1'b0;
        data_rx_d = mode_q.lsb_first ? (rx_q >> (MAX_WIDTH - int'(w_q))) : rx_q;
        if (!mode_q.hold_cs) cs_n_d = '1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_lead || enter_trail) sclk_d = ~sclk_q;
    do_sample = (enter_lead && !mode_q.cpha) || (enter_trail && mode_q.cpha);
    do_drive  = (enter_lead && mode_q.cpha) || (enter_trail && !mode_q.cpha);
    // LSB-first words fill from the top so one right shift at the end right-justifies them.
    if (do_sample) begin
      rx_d   = mode_q.lsb_first ? {miso, rx_q[MAX_WIDTH-1:1]} : {rx_q[MAX_WIDTH-2:0], miso};
      bits_d = bits_q - 1'b1;
    end
    if (do_drive) begin
      mosi_d = tx_q[MAX_WIDTH-1];
      tx_d   = tx_q << 1;
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      w_q       <= '0;
      bits_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      w_q       <= w_d;
      bits_q    <= bits_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign data_rx = data_rx_q;

endmodule
